max_pool_stream: RTL and testbench

//  Streaming, parametrised max-pool reduction for the SPPF stage: consumes a KxK window

---
 rtl/maxpool_pkg.sv | 30 +++
 rtl/max_lane_tree.sv | 43 ++++
 rtl/max_pool_stream.sv | 166 ++++++++++++++++
 tb/tb_max_pool_stream.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared state encoding, default widths and width helpers for the streaming max-pool block.
package maxpool_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam logic [DEF_DATA_WIDTH-1:0] NEG_INF = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int win_w(input int max_win);
    return $clog2(max_win + 1);
  endfunction

  function automatic int idx_w(input int max_win);
    return (max_win > 1) ? $clog2(max_win * max_win) : 1;
  endfunction

  // Element counter must reach N plus one extra beat of lanes
  function automatic int cnt_w(input int max_win, input int lanes);
    return $clog2(max_win * max_win + lanes + 1);
  endfunction

  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/max_lane_tree.sv
// Combinational signed max across one beat of lanes; masked lanes count as NEG_INF.
// With MAXPOOL_ARGMAX_EN defined it also reports the earliest winning lane.
module max_lane_tree
  import maxpool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LANES      = 4
) (
  input  logic [DATA_WIDTH*LANES-1:0]  data_i,
  input  logic [LANES-1:0]             mask_i,
`ifdef MAXPOOL_ARGMAX_EN
  output logic [lane_w(LANES)-1:0]     lane_o,
`endif
  output logic signed [DATA_WIDTH-1:0] max_o
);

  localparam logic signed [DATA_WIDTH-1:0] NEG_INF_W = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`ifdef MAXPOOL_ARGMAX_EN
  localparam int unsigned LANE_W = lane_w(LANES);
`endif

  logic signed [DATA_WIDTH-1:0] lane_val;

  // Lane 0 sits in the MSBs; strict compare keeps the lowest lane on ties
  always_comb begin
    max_o    = NEG_INF_W;
    lane_val = NEG_INF_W;
`ifdef MAXPOOL_ARGMAX_EN
    lane_o   = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      lane_val = mask_i[i] ? NEG_INF_W
                           : $signed(data_i[(LANES-1-i)*DATA_WIDTH +: DATA_WIDTH]);
      if (lane_val > max_o) begin
        max_o  = lane_val;
`ifdef MAXPOOL_ARGMAX_EN
        lane_o = LANE_W'(i);
`endif
      end
    end
  end

endmodule

// File: rtl/max_pool_stream.sv
// Streaming KxK signed max-pool: LANES elements per beat, one result per window.
// Define MAXPOOL_ARGMAX_EN to drive out_idx with the flat argmax index; otherwise out_idx is 0.
module max_pool_stream
  import maxpool_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned  LANES      = 4,
  parameter int unsigned  MAX_WIN    = 13,
  localparam int unsigned WIN_W      = win_w(MAX_WIN),
  localparam int unsigned IDX_W      = idx_w(MAX_WIN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIN_W-1:0]            cfg_win,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH*LANES-1:0] in_data,
  input  logic [LANES-1:0]            in_pad,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_max,
  output logic [IDX_W-1:0]            out_idx
);

  localparam int unsigned      CNT_W = cnt_w(MAX_WIN, LANES);
  localparam logic [WIN_W-1:0] MAX_K = WIN_W'(MAX_WIN);

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] out_max_q, out_max_d;
  logic [CNT_W-1:0] base_q, base_d;
  logic [CNT_W-1:0] n_q, n_d;

  logic [WIN_W-1:0] k_eff_c;
  logic [CNT_W-1:0] n_cfg_c, n_cur_c, base_cur_c;
  logic [LANES-1:0] mask_c;
  logic             fire_c, last_c, upd_c;
  logic signed [DATA_WIDTH-1:0] beat_max_c, win_max_c;

`ifdef MAXPOOL_ARGMAX_EN
  localparam int unsigned LANE_W = lane_w(LANES);
  logic [LANE_W-1:0] beat_lane_c;
  logic [IDX_W-1:0]  idx_q, idx_d, out_idx_q, out_idx_d, win_idx_c;
`endif

  // Clamp requested window side to 1..MAX_WIN
  always_comb begin
    k_eff_c = cfg_win;
    if (cfg_win == '0) begin
      k_eff_c = WIN_W'(1);
    end else if (cfg_win > MAX_K) begin
      k_eff_c = MAX_K;
    end
  end

  // The first beat of a window uses the live config; later beats use the latched N
  assign n_cfg_c    = CNT_W'(k_eff_c) * CNT_W'(k_eff_c);
  assign n_cur_c    = (state_q == IDLE) ? n_cfg_c : n_q;
  assign base_cur_c = (state_q == IDLE) ? '0 : base_q;
  assign fire_c     = in_valid & in_ready_q;
  assign last_c     = (base_cur_c + CNT_W'(LANES)) >= n_cur_c;

  always_comb begin
    mask_c = in_pad;
    for (int i = 0; i < LANES; i++) begin
      if ((base_cur_c + CNT_W'(i)) >= n_cur_c) mask_c[i] = 1'b1;
    end
  end

  max_lane_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_tree (
    .data_i (in_data),
    .mask_i (mask_c),
`ifdef MAXPOOL_ARGMAX_EN
    .lane_o (beat_lane_c),
`endif
    .max_o  (beat_max_c)
  );

  // First beat seeds the accumulator; later beats replace it only when strictly greater
  assign upd_c     = (state_q == IDLE) || (beat_max_c > acc_q);
  assign win_max_c = upd_c ? beat_max_c : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: if (fire_c) state_d = last_c ? HOLD : ACCUM;
      HOLD:        if (out_ready) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    base_d      = base_q;
    n_d         = n_q;
    out_max_d   = out_max_q;
    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
    if (fire_c) begin
      acc_d  = win_max_c;
      base_d = base_cur_c + CNT_W'(LANES);
      n_d    = n_cur_c;
      if (last_c) out_max_d = win_max_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      out_max_q   <= '0;
      base_q      <= '0;
      n_q         <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      out_max_q   <= out_max_d;
      base_q      <= base_d;
      n_q         <= n_d;
    end
  end

`ifdef MAXPOOL_ARGMAX_EN
  assign win_idx_c = upd_c ? (IDX_W'(base_cur_c) + IDX_W'(beat_lane_c)) : idx_q;

  always_comb begin
    idx_d     = idx_q;
    out_idx_d = out_idx_q;
    if (fire_c) begin
      idx_d = win_idx_c;
      if (last_c) out_idx_d = win_idx_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      out_idx_q <= '0;
    end else begin
      idx_q     <= idx_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign out_idx = out_idx_q;
`else
  assign out_idx = '0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_max   = out_max_q;

endmodule

// File: tb/tb_max_pool_stream.sv
// Self-checking bench for max_pool_stream: directed windows plus random windows vs a flat-list model.
module tb_max_pool_stream;
  import maxpool_pkg::*;

  localparam int unsigned DW   = 16;
  localparam int unsigned LN   = 4;
  localparam int unsigned MW   = 13;
  localparam int unsigned WW   = $clog2(MW + 1);
  localparam int unsigned IW   = $clog2(MW * MW);
  localparam int unsigned MAXE = MW * MW + LN;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [WW-1:0] cfg_win;
  logic          in_valid;
  logic          in_ready;
  logic [DW*LN-1:0] in_data;
  logic [LN-1:0] in_pad;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_max;
  logic [IW-1:0] out_idx;

  max_pool_stream #(.DATA_WIDTH(DW), .LANES(LN), .MAX_WIN(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_win   (cfg_win),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pad    (in_pad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] win_val [MAXE];
  bit            win_pad [MAXE];
  logic [DW-1:0] exp_max;
  logic [IW-1:0] exp_idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int keff(input int cfg);
    if (cfg == 0) return 1;
    return (cfg > int'(MW)) ? int'(MW) : cfg;
  endfunction

  // Window = first K*K entries of the flat list; pads are NEG_INF; earliest strict max wins
  task automatic model(input int cfg);
    int n, best, bi, v;
    n    = keff(cfg) * keff(cfg);
    best = -32768;
    bi   = 0;
    for (int e = 0; e < n; e++) begin
      v = win_pad[e] ? -32768 : int'($signed(win_val[e]));
      if (v > best) begin
        best = v;
        bi   = e;
      end
    end
    exp_max = DW'(best);
`ifdef MAXPOOL_ARGMAX_EN
    exp_idx = IW'(bi);
`else
    exp_idx = '0;
`endif
  endtask

  task automatic fill_random(input bit narrow);
    for (int e = 0; e < int'(MAXE); e++) begin
      win_val[e] = narrow ? (DW'($urandom_range(0, 15)) - 16'd8) : DW'($urandom);
      win_pad[e] = ($urandom_range(0, 7) == 0);
    end
  endtask

  // Sends beats of the current window; nbeats < 0 sends the whole window
  task automatic send_window(input int cfg, input bit gaps, input int nbeats);
    int n, beats, lim, guard;
    n     = keff(cfg) * keff(cfg);
    beats = (n + int'(LN) - 1) / int'(LN);
    lim   = (nbeats < 0) ? beats : nbeats;
    for (int b = 0; b < lim; b++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          tick();
        end
      end
      for (int l = 0; l < int'(LN); l++) begin
        in_data[(int'(LN)-1-l)*int'(DW) +: DW] = win_val[b*int'(LN)+l];
        in_pad[l] = win_pad[b*int'(LN)+l];
      end
      cfg_win  = (b == 0) ? WW'(cfg) : WW'($urandom);
      in_valid = 1'b1;
      guard    = 0;
      while (in_ready !== 1'b1 && guard < 200) begin
        tick();
        guard++;
      end
      if (guard != 0) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Drains one result, optionally with random back-pressure; values must hold while stalled
  task automatic collect(input bit rand_ready, input string tag);
    int guard;
    bit done;
    guard = 0;
    done  = 1'b0;
    check({tag, "_latency"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
    while (!done && guard < 100) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      check({tag, "_max"}, {16'd0, out_max}, {16'd0, exp_max});
      check({tag, "_idx"}, {24'd0, out_idx}, {24'd0, exp_idx});
      if (out_valid !== 1'b1) break;
      tick();
      guard++;
      if (out_ready) done = 1'b1;
    end
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [DW-1:0] hold_max;
    logic [IW-1:0] hold_idx;

    rst_n     = 1'b0;
    cfg_win   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_pad    = '0;
    out_ready = 1'b0;
    for (int e = 0; e < int'(MAXE); e++) begin
      win_val[e] = '0;
      win_pad[e] = 1'b0;
    end
    repeat (3) tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_max", {16'd0, out_max}, 32'd0);
    check("rst_out_idx", {24'd0, out_idx}, 32'd0);
    rst_n = 1'b1;
    tick();

    // K=1: only lane 0 counts
    win_val[0] = 16'd7; win_val[1] = 16'hFFFD; win_val[2] = 16'd5; win_val[3] = 16'd9;
    send_window(1, 1'b0, -1);
    model(1);
    check("k1_model_max", {16'd0, exp_max}, 32'd7);
    collect(1'b0, "k1");

    // K=3: tail lanes of the third beat are masked
    win_val[0] = 16'd1; win_val[1] = 16'd2; win_val[2] = 16'd3; win_val[3] = 16'd4;
    win_val[4] = 16'd9; win_val[5] = 16'd0; win_val[6] = 16'd0; win_val[7] = 16'd0;
    for (int e = 8; e < 12; e++) win_val[e] = 16'hFFFF;
    send_window(3, 1'b0, -1);
    model(3);
    collect(1'b0, "k3");

    // K=5 fully padded
    for (int e = 0; e < int'(MAXE); e++) begin
      win_val[e] = 16'hFF9C;
      win_pad[e] = 1'b1;
    end
    send_window(5, 1'b0, -1);
    model(5);
    collect(1'b0, "k5_pad");

    // K=5 tie at 6 and 20, larger garbage beyond N must be masked
    for (int e = 0; e < int'(MAXE); e++) begin
      win_val[e] = DW'($urandom_range(0, 54)) - 16'd50;
      win_pad[e] = 1'b0;
    end
    win_val[6] = 16'd5; win_val[20] = 16'd5;
    win_val[25] = 16'd100; win_val[26] = 16'd100; win_val[27] = 16'd100;
    send_window(5, 1'b0, -1);
    model(5);
    collect(1'b0, "k5_tie");

    // Long stall with the next beat already presented; that beat must not be lost
    fill_random(1'b0);
    send_window(2, 1'b0, -1);
    model(2);
    hold_max = exp_max;
    hold_idx = exp_idx;
    in_data  = {16'd42, 48'($urandom)};
    in_pad   = '0;
    cfg_win  = WW'(1);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_max", {16'd0, out_max}, {16'd0, hold_max});
      check("hold_idx", {24'd0, out_idx}, {24'd0, hold_idx});
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_release_valid", {31'd0, out_valid}, 32'd0);
    check("hold_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    exp_max  = 16'd42;
    exp_idx  = '0;
    collect(1'b0, "hold_next");

    // K=13 random windows with input gaps and output back-pressure
    for (int w = 0; w < 100; w++) begin
      fill_random(w[0]);
      send_window(13, 1'b1, -1);
      model(13);
      collect(1'b1, "rand_k13");
    end

    // Random window sizes including 0 and values above MAX_WIN
    for (int w = 0; w < 20; w++) begin
      int cfg;
      cfg = int'($urandom_range(0, 15));
      fill_random(w[0]);
      send_window(cfg, 1'b1, -1);
      model(cfg);
      collect(1'b1, "rand_cfg");
    end

    // Reset in the middle of a K=9 window
    fill_random(1'b0);
    send_window(9, 1'b0, 5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_max", {16'd0, out_max}, 32'd0);
    check("midrst_out_idx", {24'd0, out_idx}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_no_output", {31'd0, out_valid}, 32'd0);
    fill_random(1'b0);
    send_window(9, 1'b1, -1);
    model(9);
    collect(1'b1, "post_rst_k9");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
